pipe_barrel_shifter: RTL and testbench

PIPE_BARREL_SHIFTER -- requirements
Module: pipe_barrel_shifter

---
 rtl/bsh_pkg.sv | 33 +++
 rtl/bsh_stage.sv | 66 ++++++
 rtl/pipe_barrel_shifter.sv | 68 ++++++
 tb/tb_pipe_barrel_shifter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsh_pkg.sv
// Shared types for the pipelined barrel shifter.
// Optional feature macro: BSH_ROTATE_EN (enables the ROR operation).
package bsh_pkg;

   // Payload fields are sized for the largest supported WIDTH (128);
   // narrower builds use the low bits and keep the rest at zero.
   localparam int BSH_MAX_W   = 128;
   localparam int BSH_SHW_MAX = 7;

   typedef enum logic [1:0] {
      BSH_SLL = 2'd0,
      BSH_SRL = 2'd1,
      BSH_SRA = 2'd2,
      BSH_ROR = 2'd3
   } bsh_op_e;

   typedef struct packed {
      logic [BSH_MAX_W-1:0]   data;
      bsh_op_e                op;
      logic [BSH_SHW_MAX-1:0] shamt;
      logic                   sign;
   } bsh_pl_t;

   // An op is legal unless it is ROR and rotate support is compiled out.
   function automatic logic bsh_op_legal(bsh_op_e op);
`ifdef BSH_ROTATE_EN
      bsh_op_legal = 1'b1;
`else
      bsh_op_legal = (op != BSH_ROR);
`endif
   endfunction

endpackage

// File: rtl/bsh_stage.sv
// One barrel-shifter stage: conditional shift by 2^K plus its pipeline register.
// Optional feature macro: BSH_ROTATE_EN (adds the rotate path).
module bsh_stage
   import bsh_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int K     = 0
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    flush,
   input  logic    en,
   input  logic    in_valid,
   input  bsh_pl_t in_pl,
   output logic    out_valid,
   output bsh_pl_t out_pl
);

   localparam int AMT = 1 << K;

   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] fill;
   bsh_pl_t          nxt;
   logic             unused_hi;

   // Bits above WIDTH are always zero; folded here so they count as read.
   assign unused_hi = |(in_pl.data >> WIDTH);

   // Shift by AMT when this stage's shamt bit is set; otherwise pass through.
   always_comb begin
      d    = in_pl.data[WIDTH-1:0];
      sh   = d;
      fill = {WIDTH{in_pl.sign}} << (WIDTH - AMT);
      if (in_pl.shamt[K]) begin
         case (in_pl.op)
            BSH_SLL: sh = d << AMT;
            BSH_SRL: sh = d >> AMT;
            BSH_SRA: sh = (d >> AMT) | fill;
`ifdef BSH_ROTATE_EN
            BSH_ROR: sh = (d >> AMT) | (d << (WIDTH - AMT));
`else
            BSH_ROR: sh = d;
`endif
            default: sh = d;
         endcase
      end
      nxt                  = in_pl;
      nxt.data             = '0;
      nxt.data[WIDTH-1:0]  = sh;
   end

   // Pipeline register: flush clears valid, a low enable holds everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_pl    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (en) begin
         out_valid <= in_valid;
         out_pl    <= nxt;
      end
   end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR, one stage per shamt bit,
// valid/ready handshake with a global stall enable.
// Optional feature macro: BSH_ROTATE_EN (ROR legal; otherwise op 3 flags out_err).
module pipe_barrel_shifter
   import bsh_pkg::*;
#(
   parameter  int WIDTH = 64,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err
);

   logic     en;
   logic     v  [SHW+1];
   bsh_pl_t  pl [SHW+1];
   logic     legal;
   logic     unused_tail;

   // The whole pipe advances together unless a result is stuck at the output.
   assign en       = !v[SHW] || out_ready;
   assign in_ready = en;
   assign v[0]     = in_valid;

   // Capture the operand; the sign bit rides along for the SRA fill.
   always_comb begin
      pl[0]       = '0;
      pl[0].data  = BSH_MAX_W'(in_data);
      pl[0].op    = bsh_op_e'(in_op);
      pl[0].shamt = BSH_SHW_MAX'(in_shamt);
      pl[0].sign  = in_data[WIDTH-1];
   end

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      bsh_stage #(
         .WIDTH (WIDTH),
         .K     (k)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .en        (en),
         .in_valid  (v[k]),
         .in_pl     (pl[k]),
         .out_valid (v[k+1]),
         .out_pl    (pl[k+1])
      );
   end

   assign legal     = bsh_op_legal(pl[SHW].op);
   assign out_valid = v[SHW];
   assign out_data  = (v[SHW] && legal) ? pl[SHW].data[WIDTH-1:0] : '0;
   assign out_err   = v[SHW] && !legal;

   // Fields the last stage carries but the output does not need.
   assign unused_tail = ^{pl[SHW].shamt, pl[SHW].sign, pl[SHW].data >> WIDTH};

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Scoreboard bench for pipe_barrel_shifter (WIDTH=64, six-cycle latency).
module tb_pipe_barrel_shifter;

   localparam int WIDTH = 64;
   localparam int SHW   = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic [SHW-1:0]   in_shamt = '0;
   logic [1:0]       in_op = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_data;
   logic             out_err;

   pipe_barrel_shifter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [64:0] exp;
      int          cyc;
   } sb_t;

   sb_t          sb[$];
   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   int           pops = 0;
   int           ready_mode = 0;
   int           stall_from = 0;
   bit           lat_chk = 1'b0;
   bit           last_acc = 1'b0;
   logic         prev_hold = 1'b0;
   logic [63:0]  held = '0;

   task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: {err, data} from whole-word shift operators.
   function automatic logic [64:0] model(input logic [63:0] d, input logic [5:0] sh,
                                         input logic [1:0] op);
      logic [63:0] r;
      logic        e;
      e = 1'b0;
      case (op)
         2'd0:    r = d << sh;
         2'd1:    r = d >> sh;
         2'd2:    r = 64'($signed(d) >>> sh);
`ifdef BSH_ROTATE_EN
         default: r = (d >> sh) | (d << (64 - int'(sh)));
`else
         default: begin r = '0; e = 1'b1; end
`endif
      endcase
      return {e, r};
   endfunction

   // One clock: set out_ready, sample at negedge+1, score, then advance.
   task automatic cycle();
      sb_t e;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         2:       out_ready = !(cyc >= stall_from && cyc < stall_from + 10);
         default: out_ready = 1'b0;
      endcase
      #1;
      if (prev_hold) begin
         check("hold_valid", 65'(out_valid), 65'(1));
         check("hold_data", {1'b0, out_data}, {1'b0, held});
      end
      if (out_valid && !out_ready) check("stall_in_ready", 65'(in_ready), 65'(0));
      if (!out_valid) check("idle_zero", {out_err, out_data}, 65'(0));
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_out", 65'(1), 65'(0));
         end else begin
            e = sb.pop_front();
            pops++;
            check("result", {out_err, out_data}, e.exp);
            if (lat_chk) check("latency", 65'(cyc - e.cyc), 65'(6));
         end
      end
      last_acc = in_valid && in_ready && !flush;
      if (flush) sb.delete();
      else if (last_acc) sb.push_back('{model(in_data, in_shamt, in_op), cyc});
      prev_hold = out_valid && !out_ready && !flush;
      held      = out_data;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic send(input logic [63:0] d, input logic [5:0] sh, input logic [1:0] op);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = sh;
      in_op    = op;
      for (int i = 0; i < 100 && !done; i++) begin
         cycle();
         done = last_acc;
      end
      if (!done) check("send_timeout", 65'(0), 65'(1));
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 300 && sb.size() > 0; i++) cycle();
      if (sb.size() > 0) check("drain_timeout", 65'(sb.size()), 65'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int p0;
      @(negedge clk);
      check("rst_out_valid", 65'(out_valid), 65'(0));
      check("rst_out", {out_err, out_data}, 65'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 65'(in_ready), 65'(1));
      @(negedge clk);

      // SRA sign fill with latency check
      lat_chk = 1'b1;
      send(64'h8000_0000_0000_0000, 6'd4, 2'd2);
      drain();
      lat_chk = 1'b0;

      // boundary shift amounts and the rotate/illegal op
      send(64'd1, 6'd63, 2'd0);
      send(64'd1, 6'd63, 2'd1);
      send(64'd1, 6'd1, 2'd3);
      drain();

      // zero shift passes data for every op
      for (int op = 0; op < 4; op++) send(64'hDEAD_BEEF_0123_4567, 6'd0, 2'(op));
      drain();

      // eight back-to-back beats with a 10-cycle output stall mid-stream
      ready_mode = 2;
      stall_from = cyc + 8;
      p0 = pops;
      for (int i = 0; i < 8; i++) send({$urandom, $urandom}, 6'($urandom), 2'(i));
      drain();
      check("stall_count", 65'(pops - p0), 65'(8));
      ready_mode = 0;

      // random traffic with random backpressure
      ready_mode = 1;
      for (int i = 0; i < 40; i++) begin
         send({$urandom, $urandom}, 6'($urandom), 2'($urandom));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      ready_mode = 0;
      drain();

      // reset with beats in flight and one held at the output
      ready_mode = 3;
      for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 6'(i + 1), 2'd1);
      idle(8);
      check("rst_pre_valid", 65'(out_valid), 65'(1));
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_valid", 65'(out_valid), 65'(0));
      check("rst_async_out", {out_err, out_data}, 65'(0));
      sb.delete();
      prev_hold = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ready_mode = 0;
      idle(12);
      check("post_rst_in_ready", 65'(in_ready), 65'(1));

      // flush with a beat offered in the same cycle
      for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 6'($urandom), 2'd0);
      in_valid = 1'b1;
      in_data  = 64'h1234_5678_9ABC_DEF0;
      flush    = 1'b1;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("flush_empty", 65'(out_valid), 65'(0));
      idle(12);
      send(64'h0F, 6'd2, 2'd0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
